// File: rtl/isqrt_result_checker.sv
// isqrt_result_checker
//   Checks each result of the pipelined integer square root in hardware.
//   The radicand is delayed by the isqrt latency so that it lines up with the
//   root. The checker then tests y*y <= x < (y+1)*(y+1). It reports a
//   per-sample verdict and the remainder, and keeps saturating check and
//   error counters.
//   Optional feature macro: ISQRT_CHECK_FIRST_ERR_EN. When it is defined, the
//   checker captures the first failing {x, y} after reset or clear.
//   Note: reset_n is active-high despite its name.

module isqrt_result_checker #(
    parameter int X_WIDTH   = 32,
    parameter int Y_WIDTH   = 16,
    parameter int LATENCY   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [X_WIDTH-1:0]   x_in,
    input  logic [Y_WIDTH-1:0]   y_in,
    output logic                 out_valid,
    output logic [X_WIDTH-1:0]   x_out,
    output logic [Y_WIDTH-1:0]   y_out,
    output logic [Y_WIDTH:0]     remainder,
    output logic                 err_low,
    output logic                 err_high,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] check_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [X_WIDTH-1:0]   first_err_x,
    output logic [Y_WIDTH-1:0]   first_err_y
);

    logic                 vld_dly [LATENCY];
    logic [X_WIDTH-1:0]   x_dly   [LATENCY];

    logic                 tail_valid;
    logic [X_WIDTH-1:0]   tail_x;
    logic [2*Y_WIDTH-1:0] sq;
    logic [Y_WIDTH:0]     y_plus1;
    logic [2*Y_WIDTH:0]   sq1;
    logic                 sq_gt_x;
    logic                 chk_low;
    logic                 chk_high;
    logic                 chk_err;
    logic [Y_WIDTH:0]     chk_rem;

    assign tail_valid = vld_dly[LATENCY-1];
    assign tail_x     = x_dly[LATENCY-1];

    // Delay line that mirrors the isqrt pipeline. It never stalls, and reset flushes it.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_dly[i] <= 1'b0;
                x_dly[i]   <= '0;
            end
        end else begin
            vld_dly[0] <= in_valid;
            x_dly[0]   <= x_in;
            for (int i = 1; i < LATENCY; i++) begin
                vld_dly[i] <= vld_dly[i-1];
                x_dly[i]   <= x_dly[i-1];
            end
        end
    end

    // Bound check of the arriving root. (y+1)^2 gets one extra bit so it cannot overflow at y = all-ones.
    always_comb begin
        sq       = {{Y_WIDTH{1'b0}}, y_in} * {{Y_WIDTH{1'b0}}, y_in};
        y_plus1  = {1'b0, y_in} + {{Y_WIDTH{1'b0}}, 1'b1};
        sq1      = {{Y_WIDTH{1'b0}}, y_plus1} * {{Y_WIDTH{1'b0}}, y_plus1};
        sq_gt_x  = (sq > tail_x);
        chk_low  = tail_valid && sq_gt_x;
        chk_high = tail_valid && ({1'b0, tail_x} >= sq1);
        chk_err  = chk_low || chk_high;
        chk_rem  = sq_gt_x ? '0 : (tail_x[Y_WIDTH:0] - sq[Y_WIDTH:0]);
    end

    // Per-sample result registers. The data fields hold their value while no check is present.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            out_valid <= 1'b0;
            err_low   <= 1'b0;
            err_high  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            remainder <= '0;
        end else begin
            out_valid <= tail_valid;
            err_low   <= chk_low;
            err_high  <= chk_high;
            if (tail_valid) begin
                x_out     <= tail_x;
                y_out     <= y_in;
                remainder <= chk_rem;
            end
        end
    end

    // Saturating statistics. A clear on the same edge as a check suppresses the counting of that check.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            check_count <= '0;
            err_count   <= '0;
            err_sticky  <= 1'b0;
        end else if (clear) begin
            check_count <= '0;
            err_count   <= '0;
            err_sticky  <= 1'b0;
        end else if (tail_valid) begin
            if (check_count != '1) begin
                check_count <= check_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (chk_err) begin
                err_sticky <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef ISQRT_CHECK_FIRST_ERR_EN
    logic first_seen;

    // Capture of the first failing sample. An error on the same edge as a clear is still captured.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            first_seen  <= 1'b0;
            first_err_x <= '0;
            first_err_y <= '0;
        end else if (clear) begin
            first_seen  <= chk_err;
            first_err_x <= chk_err ? tail_x : '0;
            first_err_y <= chk_err ? y_in : '0;
        end else if (chk_err && !first_seen) begin
            first_seen  <= 1'b1;
            first_err_x <= tail_x;
            first_err_y <= y_in;
        end
    end
`else
    assign first_err_x = '0;
    assign first_err_y = '0;
`endif

endmodule

// File: tb/tb_isqrt_result_checker.sv
// Testbench for isqrt_result_checker.
//   A scoreboard holds the expected check result of every driven sample.
//   Each entry is due LATENCY edges after its sample. A second instance with
//   CNT_WIDTH=4 shares the stimulus so that counter saturation can be observed.
`timescale 1ns/1ps

module tb_isqrt_result_checker;

    localparam int L = 16;

    typedef struct {
        int          due;
        logic [31:0] x;
        logic [15:0] y;
        bit          el;
        bit          eh;
        logic [16:0] rem;
    } expEntry_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] x_in = '0;
    logic [15:0] y_in = '0;

    logic        out_valid, err_low, err_high, err_sticky;
    logic [31:0] x_out, first_err_x;
    logic [15:0] y_out, first_err_y, check_count, err_count;
    logic [16:0] remainder;

    logic        outValid4, errLow4, errHigh4, errSticky4;
    logic [31:0] xOut4, firstErrX4;
    logic [15:0] yOut4, firstErrY4;
    logic [16:0] remainder4;
    logic [3:0]  checkCount4, errCount4;

    expEntry_t   sbQ[$];
    logic [15:0] ySched [int];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    bit          mValid, mEl, mEh, mSticky, mSeen;
    logic [31:0] mX, mFx;
    logic [15:0] mY, mFy;
    logic [16:0] mRem;
    int          mChk, mErr, mChk4, mErr4;

    isqrt_result_checker u_dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .x_out(x_out),
        .y_out(y_out), .remainder(remainder), .err_low(err_low),
        .err_high(err_high), .err_sticky(err_sticky), .check_count(check_count),
        .err_count(err_count), .first_err_x(first_err_x), .first_err_y(first_err_y)
    );

    isqrt_result_checker #(.CNT_WIDTH(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .x_in(x_in), .y_in(y_in), .out_valid(outValid4), .x_out(xOut4),
        .y_out(yOut4), .remainder(remainder4), .err_low(errLow4),
        .err_high(errHigh4), .err_sticky(errSticky4), .check_count(checkCount4),
        .err_count(errCount4), .first_err_x(firstErrX4), .first_err_y(firstErrY4)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Reference integer square root, computed by bitwise construction.
    function automatic logic [15:0] isqrtGold(input logic [31:0] x);
        longint unsigned r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= 64'(x)) r = t;
        end
        return 16'(r);
    endfunction

    task automatic resetModel();
        mValid = 0; mEl = 0; mEh = 0; mSticky = 0; mSeen = 0;
        mX = '0; mY = '0; mRem = '0; mFx = '0; mFy = '0;
        mChk = 0; mErr = 0; mChk4 = 0; mErr4 = 0;
    endtask

    // Advances the reference model by one edge.
    task automatic updateModel(input bit clr);
        bit        hv, er;
        expEntry_t e;
        hv = (sbQ.size() > 0) && (sbQ[0].due == cyc);
        er = 0;
        if (hv) begin
            e = sbQ.pop_front();
            mValid = 1; mX = e.x; mY = e.y; mRem = e.rem; mEl = e.el; mEh = e.eh;
            er = e.el | e.eh;
        end else begin
            mValid = 0; mEl = 0; mEh = 0;
        end
        if (clr) begin
            mChk = 0; mErr = 0; mChk4 = 0; mErr4 = 0; mSticky = 0;
`ifdef ISQRT_CHECK_FIRST_ERR_EN
            mSeen = er;
            mFx = er ? mX : 32'd0;
            mFy = er ? mY : 16'd0;
`endif
        end else if (hv) begin
            if (mChk < 65535) mChk++;
            if (mChk4 < 15) mChk4++;
            if (er) begin
                mSticky = 1;
                if (mErr < 65535) mErr++;
                if (mErr4 < 15) mErr4++;
`ifdef ISQRT_CHECK_FIRST_ERR_EN
                if (!mSeen) begin
                    mSeen = 1; mFx = mX; mFy = mY;
                end
`endif
            end
        end
    endtask

    task automatic checkCycle();
        checkOutput("out_valid", 64'(out_valid), 64'(mValid));
        checkOutput("err_low", 64'(err_low), 64'(mEl));
        checkOutput("err_high", 64'(err_high), 64'(mEh));
        checkOutput("x_out", 64'(x_out), 64'(mX));
        checkOutput("y_out", 64'(y_out), 64'(mY));
        checkOutput("remainder", 64'(remainder), 64'(mRem));
        checkOutput("err_sticky", 64'(err_sticky), 64'(mSticky));
        checkOutput("check_count", 64'(check_count), 64'(mChk));
        checkOutput("err_count", 64'(err_count), 64'(mErr));
        checkOutput("first_err_x", 64'(first_err_x), 64'(mFx));
        checkOutput("first_err_y", 64'(first_err_y), 64'(mFy));
        checkOutput("c4_out_valid", 64'(outValid4), 64'(mValid));
        checkOutput("c4_err_high", 64'(errHigh4), 64'(mEh));
        checkOutput("c4_err_sticky", 64'(errSticky4), 64'(mSticky));
        checkOutput("c4_check_count", 64'(checkCount4), 64'(mChk4));
        checkOutput("c4_err_count", 64'(errCount4), 64'(mErr4));
    endtask

    // Drives one edge. When v=1, y is the root that the modelled isqrt returns L edges later.
    task automatic applyStimulus(input bit v, input logic [31:0] x, input logic [15:0] y, input bit clr);
        expEntry_t       e;
        longint unsigned xv, sqv, sq1v;
        in_valid = v;
        x_in     = x;
        clear    = clr;
        if (ySched.exists(cyc)) begin
            y_in = ySched[cyc];
            ySched.delete(cyc);
        end else begin
            y_in = 16'($urandom);
        end
        if (v) begin
            xv   = 64'(x);
            sqv  = 64'(y) * 64'(y);
            sq1v = (64'(y) + 1) * (64'(y) + 1);
            e.due = cyc + L;
            e.x   = x;
            e.y   = y;
            e.el  = (sqv > xv);
            e.eh  = (xv >= sq1v);
            e.rem = e.el ? 17'd0 : 17'(xv - sqv);
            sbQ.push_back(e);
            ySched[cyc + L] = y;
        end
        @(posedge clock);
        #1;
        updateModel(clr);
        checkCycle();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, $urandom, 16'($urandom), 0);
    endtask

    // Holds reset for n edges with random inputs, then releases it away from the clock edge.
    task automatic doReset(input int n);
        reset_n = 1'b1;
        #1;
        sbQ.delete();
        resetModel();
        repeat (n) begin
            @(posedge clock);
            #1;
            in_valid = 1'($urandom);
            x_in     = $urandom;
            y_in     = 16'($urandom);
            checkCycle();
            cyc++;
        end
        @(negedge clock);
        reset_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        doReset(20);

        // Sweep of x = 0..255 with golden roots.
        for (int i = 0; i < 256; i++) applyStimulus(1, 32'(i), isqrtGold(32'(i)), 0);
        idle(L);
        checkOutput("t1_check_count", 64'(check_count), 64'd256);
        checkOutput("t1_err_count", 64'(err_count), 64'd0);
        checkOutput("t1_x_out_255", 64'(x_out), 64'd255);
        checkOutput("t1_y_out_255", 64'(y_out), 64'd15);
        checkOutput("t1_rem_255", 64'(remainder), 64'd30);

        // Arithmetic extremes.
        applyStimulus(1, 32'hFFFF_FFFF, 16'hFFFF, 0);
        idle(L);
        checkOutput("t2_rem_max", 64'(remainder), 64'h1FFFE);
        checkOutput("t2_y_max", 64'(y_out), 64'hFFFF);
        checkOutput("t2_err_max", 64'(err_count), 64'd0);
        applyStimulus(1, 32'd0, 16'd0, 0);
        idle(L);
        checkOutput("t2_rem_zero", 64'(remainder), 64'd0);
        checkOutput("t2_sticky_zero", 64'(err_sticky), 64'd0);

        // Injected faults: one root too small, then one root too large.
        applyStimulus(1, 32'd16, 16'd3, 0);
        applyStimulus(1, 32'd15, 16'd4, 0);
        idle(L);
        checkOutput("t3_err_count", 64'(err_count), 64'd2);
        checkOutput("t3_err_sticky", 64'(err_sticky), 64'd1);
        checkOutput("t3_rem_low", 64'(remainder), 64'd0);
`ifdef ISQRT_CHECK_FIRST_ERR_EN
        checkOutput("t3_first_x", 64'(first_err_x), 64'd16);
        checkOutput("t3_first_y", 64'(first_err_y), 64'd3);
`endif

        // Sparse valid pattern 1,0,1,1,0.
        applyStimulus(1, 32'd200, 16'd14, 0);
        applyStimulus(0, 32'd7, 16'd0, 0);
        applyStimulus(1, 32'd1000, 16'd31, 0);
        applyStimulus(1, 32'd65535, 16'd255, 0);
        applyStimulus(0, 32'd9, 16'd0, 0);
        idle(L);
        checkOutput("t4_check_count", 64'(check_count), 64'd263);

        // Random radicands with golden roots.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] rx;
            rx = $urandom;
            applyStimulus(1, rx, isqrtGold(rx), 0);
        end
        idle(L);

        // Reset in the middle of a stream.
        for (int i = 0; i < 8; i++) applyStimulus(1, 32'(i + 40), isqrtGold(32'(i + 40)), 0);
        doReset(20);
        idle(L + 2);
        checkOutput("t5_check_count", 64'(check_count), 64'd0);
        checkOutput("t5_err_count", 64'(err_count), 64'd0);

        // Saturation on the narrow counters, then a clear on the same edge as an error.
        applyStimulus(0, 32'd0, 16'd0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 32'(100 + i), 16'd0, 0);
        idle(L);
        checkOutput("t6_c4_err_count", 64'(errCount4), 64'd15);
        checkOutput("t6_c4_check_count", 64'(checkCount4), 64'd15);
        checkOutput("t6_err_count", 64'(err_count), 64'd20);
        applyStimulus(1, 32'd50, 16'd2, 0);
        idle(L - 1);
        applyStimulus(0, 32'd0, 16'd0, 1);
        checkOutput("t6_clr_err_high", 64'(err_high), 64'd1);
        checkOutput("t6_clr_c4_err", 64'(errCount4), 64'd0);
        checkOutput("t6_clr_c4_chk", 64'(checkCount4), 64'd0);
`ifdef ISQRT_CHECK_FIRST_ERR_EN
        checkOutput("t6_clr_first_x", 64'(first_err_x), 64'd50);
        checkOutput("t6_clr_first_y", 64'(first_err_y), 64'd2);
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
